fpu_op_scheduler: RTL

Shares the single floating-point datapath (`master`: adder/subtractor plus multiplier/divider) between two requesters. It round-robin arbitrates, registers the winning operands and control onto the datapath inputs, and waits a fixed latency. It then captures the result and IEEE flags from the add or mul side into a response register held under a valid/ready handshake. One operation is in flight at a time; the block sits between the issue logic and `master`.

---
 rtl/fpu_sched_pkg.sv | 19 +
 rtl/fpu_op_scheduler_rr_arb2.sv | 27 ++
 rtl/fpu_op_scheduler.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fpu_sched_pkg.sv
// rtl/fpu_sched_pkg.sv - shared types and constants for the FPU operation scheduler
package fpu_sched_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        MUL = 2'b10,
        DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/fpu_op_scheduler_rr_arb2.sv
// rtl/fpu_op_scheduler_rr_arb2.sv - two-way round-robin arbiter with a single last-grant pointer
module rr_arb2
    import fpu_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               accept,
    output logic               grant,
    output logic               grant_valid
);

    logic last;

    // On a tie the requester that did not win last time goes first.
    assign grant       = (req_valid == 2'b11) ? ~last : req_valid[1];
    assign grant_valid = |req_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= grant;
        end
    end

endmodule

// File: rtl/fpu_op_scheduler.sv
// rtl/fpu_op_scheduler.sv - shares one FP datapath between two requesters; optional FPU_SCHED_STATS_EN counters
module fpu_op_scheduler
    import fpu_sched_pkg::*;
#(
    parameter int LAT  = 1,
    parameter int ID_W = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [127:0]         req_fpa,
    input  logic [127:0]         req_fpb,
    input  logic [3:0]           req_op,
    input  logic [NUM_REQ-1:0]   req_db,
    input  logic [3:0]           req_rm,
    output logic [63:0]          fpu_fpa,
    output logic [63:0]          fpu_fpb,
    output logic                 fpu_db,
    output logic                 fpu_sub,
    output logic                 fpu_fdiv,
    output logic                 fpu_normal,
    output logic [1:0]           fpu_rm,
    input  logic [63:0]          fpu_add_res,
    input  logic [63:0]          fpu_mul_res,
    input  logic [4:0]           fpu_add_flags,
    input  logic [4:0]           fpu_mul_flags,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [63:0]          rsp_data,
    output logic [4:0]           rsp_flags
`ifdef FPU_SCHED_STATS_EN
    ,
    output logic [31:0]          stat_cnt0,
    output logic [31:0]          stat_cnt1
`endif
);

    state_e      state;
    logic [3:0]  cnt;
    logic        sel_mul;
    logic        grant;
    logic        grant_valid;
    logic        accept;
    op_e         g_op;
    logic [63:0] g_fpa;
    logic [63:0] g_fpb;
    logic [1:0]  g_rm;
    logic        g_db;

    rr_arb2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .accept      (accept),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign accept     = (state == IDLE) && grant_valid;
    assign req_ready  = {accept & grant, accept & ~grant};
    assign fpu_normal = 1'b1;

    assign g_op  = op_e'(grant ? req_op[3:2] : req_op[1:0]);
    assign g_fpa = grant ? req_fpa[127:64] : req_fpa[63:0];
    assign g_fpb = grant ? req_fpb[127:64] : req_fpb[63:0];
    assign g_rm  = grant ? req_rm[3:2] : req_rm[1:0];
    assign g_db  = grant ? req_db[1] : req_db[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            sel_mul   <= 1'b0;
            fpu_fpa   <= 64'd0;
            fpu_fpb   <= 64'd0;
            fpu_db    <= 1'b0;
            fpu_sub   <= 1'b0;
            fpu_fdiv  <= 1'b0;
            fpu_rm    <= 2'd0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= 64'd0;
            rsp_flags <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        fpu_fpa  <= g_fpa;
                        fpu_fpb  <= g_fpb;
                        fpu_db   <= g_db;
                        fpu_rm   <= g_rm;
                        fpu_sub  <= (g_op == SUB);
                        fpu_fdiv <= (g_op == DIV);
                        sel_mul  <= (g_op == MUL) || (g_op == DIV);
                        rsp_id   <= ID_W'(grant);
                        cnt      <= 4'(LAT);
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    cnt <= cnt - 4'd1;
                    // Datapath inputs have been stable for LAT cycles at this edge.
                    if (cnt == 4'd1) begin
                        rsp_data  <= sel_mul ? fpu_mul_res : fpu_add_res;
                        rsp_flags <= sel_mul ? fpu_mul_flags : fpu_add_flags;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FPU_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cnt0 <= 32'd0;
            stat_cnt1 <= 32'd0;
        end else if (accept) begin
            if (!grant && stat_cnt0 != 32'hFFFF_FFFF) begin
                stat_cnt0 <= stat_cnt0 + 32'd1;
            end
            if (grant && stat_cnt1 != 32'hFFFF_FFFF) begin
                stat_cnt1 <= stat_cnt1 + 32'd1;
            end
        end
    end
`endif

endmodule
